transmitter_scheduler: RTL and testbench

- Shares one Data_Transmitter (SIPO receive / PISO send datapath) among NUM_REQ requesters.
- Arbitrates round-robin, then drives mode_select, start and parallel_in for the winner.
- Times the fixed-length frame, captures parallel_out, and returns a one-cycle done pulse to the winner.
- Sits between client blocks and the Data_Transmitter instance. It does not drive the transmitter's own reset.

---
 rtl/transmitter_sched_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 31 +++
 rtl/transmitter_scheduler.sv | 151 +++++++++++++++
 tb/tb_transmitter_scheduler.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/transmitter_sched_pkg.sv
// Shared state encoding, mode constants and width helper for the transmitter scheduler.
package transmitter_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic MODE_RX = 1'b0;
  localparam logic MODE_TX = 1'b1;

  // Index width for n items, never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after rr_ptr_i, wrapping.
module rr_arbiter
  import transmitter_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   rr_ptr_i,
  output logic               any_req_c_o,
  output logic [IDX_W-1:0]   winner_c_o
);

  logic        found;
  int unsigned pos;

  always_comb begin
    found       = 1'b0;
    pos         = 0;
    winner_c_o  = '0;
    any_req_c_o = |req_i;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      pos = (32'(rr_ptr_i) + k) % NUM_REQ;
      if (!found && req_i[IDX_W'(pos)]) begin
        found      = 1'b1;
        winner_c_o = IDX_W'(pos);
      end
    end
  end

endmodule

// File: rtl/transmitter_scheduler.sv
// Shares one Data_Transmitter among NUM_REQ clients: round-robin grant, frame timing,
// receive-data capture and a one-cycle done pulse back to the winner.
module transmitter_scheduler
  import transmitter_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned FRAME_CYCLES = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_mode,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        done,
  output logic [DATA_W-1:0]         rdata,
  output logic                      busy,
  output logic                      dt_mode_select,
  output logic                      dt_start,
  output logic [DATA_W-1:0]         dt_parallel_in,
  input  logic [DATA_W-1:0]         dt_parallel_out
);

  localparam int unsigned IDX_W = idx_w(NUM_REQ);
  localparam int unsigned CNT_W = idx_w(FRAME_CYCLES);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               mode_q, mode_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic               busy_q, busy_d;
  logic               start_q, start_d;

  logic               any_req;
  logic [IDX_W-1:0]   winner;
  logic               mode_sel;
  logic [DATA_W-1:0]  data_sel;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req_i       (req),
    .rr_ptr_i    (rr_ptr_q),
    .any_req_c_o (any_req),
    .winner_c_o  (winner)
  );

  // Winner's mode and send data, selected for latching in IDLE.
  always_comb begin
    mode_sel = MODE_RX;
    data_sel = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (winner == IDX_W'(i)) begin
        mode_sel = req_mode[i];
        data_sel = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Next state; outputs are precomputed so they change with the state register.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    data_d   = data_q;
    rdata_d  = rdata_q;
    gnt_d    = gnt_q;
    done_d   = '0;
    busy_d   = busy_q;
    start_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          idx_d   = winner;
          mode_d  = mode_sel;
          data_d  = data_sel;
          gnt_d   = NUM_REQ'(1) << winner;
          start_d = 1'b1;
          busy_d  = 1'b1;
          state_d = START;
        end
      end
      START: begin
        cnt_d   = CNT_W'(FRAME_CYCLES - 1);
        state_d = BUSY;
      end
      BUSY: begin
        if (cnt_q == '0) begin
          if (mode_q != MODE_TX) rdata_d = dt_parallel_out;
          done_d  = gnt_q;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        rr_ptr_d = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + IDX_W'(1);
        gnt_d    = '0;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      mode_q   <= MODE_RX;
      data_q   <= '0;
      rdata_q  <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      busy_q   <= 1'b0;
      start_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      mode_q   <= mode_d;
      data_q   <= data_d;
      rdata_q  <= rdata_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      start_q  <= start_d;
    end
  end

  assign gnt            = gnt_q;
  assign done           = done_q;
  assign rdata          = rdata_q;
  assign busy           = busy_q;
  assign dt_start       = start_q;
  assign dt_mode_select = mode_q;
  assign dt_parallel_in = data_q;

endmodule

// File: tb/tb_transmitter_scheduler.sv
// Self-checking bench: directed scenarios plus randomized transactions against a transaction-level model.
module tb_transmitter_scheduler;

  localparam int unsigned NUM_REQ      = 4;
  localparam int unsigned DATA_W       = 8;
  localparam int unsigned FRAME_CYCLES = 10;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic [NUM_REQ-1:0]        req = '0;
  logic [NUM_REQ-1:0]        req_mode = '0;
  logic [NUM_REQ*DATA_W-1:0] req_data = '0;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        done;
  logic [DATA_W-1:0]         rdata;
  logic                      busy;
  logic                      dt_mode_select;
  logic                      dt_start;
  logic [DATA_W-1:0]         dt_parallel_in;
  logic [DATA_W-1:0]         dt_parallel_out = '0;

  int          checks = 0;
  int          passed = 0;
  int          m_ptr = 0;
  logic [7:0]  m_rdata = 8'h00;
  logic [7:0]  rx_val = 8'h00;
  int          k_cnt = 1000;

  transmitter_scheduler #(
    .NUM_REQ      (NUM_REQ),
    .DATA_W       (DATA_W),
    .FRAME_CYCLES (FRAME_CYCLES)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .req             (req),
    .req_mode        (req_mode),
    .req_data        (req_data),
    .gnt             (gnt),
    .done            (done),
    .rdata           (rdata),
    .busy            (busy),
    .dt_mode_select  (dt_mode_select),
    .dt_start        (dt_start),
    .dt_parallel_in  (dt_parallel_in),
    .dt_parallel_out (dt_parallel_out)
  );

  always #5 clk = ~clk;

  // Transmitter stand-in: received frame is valid only FRAME_CYCLES cycles after the start pulse.
  always @(negedge clk) begin
    if (dt_start === 1'b1) k_cnt = 0;
    else if (k_cnt < 1000) k_cnt = k_cnt + 1;
    dt_parallel_out = (k_cnt == int'(FRAME_CYCLES)) ? rx_val : ~rx_val;
  end

  function automatic int model_winner(input logic [3:0] r, input int ptr);
    int j;
    for (int k = 0; k < 4; k++) begin
      j = (ptr + k) % 4;
      if (((r >> j) & 4'd1) != 4'd0) return j;
    end
    return 0;
  endfunction

  task automatic wait_start(output bit ok, output int n);
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 40) begin
      @(negedge clk);
      n++;
      if (dt_start === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = '0; req_mode = '0; req_data = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({gnt, done, busy, dt_start, dt_mode_select, dt_parallel_in, rdata} !== '0)
      $display("FAIL reset_outputs got gnt=%b done=%b busy=%b st=%b ms=%b pin=%h rdata=%h exp all 0",
               gnt, done, busy, dt_start, dt_mode_select, dt_parallel_in, rdata);
    else passed++;
    rst = 1'b0;
    m_ptr = 0;
    m_rdata = 8'h00;
  endtask

  task automatic test_single_rx();
    rx_val = 8'hA5;
    req = 4'b0001; req_mode = 4'b0000;
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      if (c == 1) req = '0;
      checks++;
      if ({dt_start, busy, gnt, done} !== {logic'(c == 1), logic'(c <= 12),
                                           (c <= 12) ? 4'b0001 : 4'b0000,
                                           (c == 12) ? 4'b0001 : 4'b0000})
        $display("FAIL rx_timing c=%0d got st=%b busy=%b gnt=%b done=%b", c, dt_start, busy, gnt, done);
      else passed++;
    end
    m_rdata = 8'hA5;
    m_ptr = 1;
    checks++;
    if (rdata !== 8'hA5) $display("FAIL rx_rdata got=%h exp=%h", rdata, 8'hA5);
    else passed++;
  endtask

  task automatic test_single_tx();
    rx_val = 8'h00;
    req = 4'b0100; req_mode = 4'b0100; req_data = 32'h003C_0000;
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      if (c == 1) req = '0;
      checks++;
      if ({dt_mode_select, dt_parallel_in, gnt, done} !== {1'b1, 8'h3C,
                                                           (c <= 12) ? 4'b0100 : 4'b0000,
                                                           (c == 12) ? 4'b0100 : 4'b0000})
        $display("FAIL tx_cycle c=%0d got ms=%b pin=%h gnt=%b done=%b", c, dt_mode_select, dt_parallel_in, gnt, done);
      else passed++;
    end
    m_ptr = 3;
    checks++;
    if (rdata !== m_rdata) $display("FAIL tx_rdata_kept got=%h exp=%h", rdata, m_rdata);
    else passed++;
  endtask

  task automatic test_round_robin();
    bit ok; int n, w;
    logic [3:0] lm; logic [31:0] ld; logic [3:0] expg;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_ptr = 0; m_rdata = 8'h00;
    lm = 4'($urandom); ld = $urandom;
    req = 4'hF; req_mode = lm; req_data = ld;
    rx_val = 8'($urandom);
    for (int t = 0; t < 5; t++) begin
      wait_start(ok, n);
      checks++;
      if (!ok) begin $display("FAIL rr_start_timeout t=%0d got none exp dt_start", t); return; end
      passed++;
      w = model_winner(4'hF, m_ptr);
      expg = 4'd1 << w;
      if (t > 0) begin
        checks++;
        if (11 + n != 13) $display("FAIL rr_spacing t=%0d got=%0d exp=13", t, 11 + n);
        else passed++;
      end
      checks++;
      if ({gnt, dt_mode_select, dt_parallel_in} !== {expg, lm[w], ld[w*8 +: 8]})
        $display("FAIL rr_grant t=%0d got gnt=%b ms=%b pin=%h exp gnt=%b ms=%b pin=%h",
                 t, gnt, dt_mode_select, dt_parallel_in, expg, lm[w], ld[w*8 +: 8]);
      else passed++;
      if (!lm[w]) m_rdata = rx_val;
      repeat (11) @(negedge clk);
      checks++;
      if ({done, rdata} !== {expg, m_rdata})
        $display("FAIL rr_done t=%0d got done=%b rdata=%h exp done=%b rdata=%h", t, done, rdata, expg, m_rdata);
      else passed++;
      m_ptr = (w + 1) % 4;
      if (t == 4) req = '0;
      rx_val = 8'($urandom);
    end
  endtask

  task automatic test_mid_flight();
    bit ok; int n;
    logic [7:0] d1;
    d1 = 8'($urandom);
    rx_val = 8'($urandom);
    req_data = $urandom;
    req_data[15:8] = d1;
    req = 4'b0010; req_mode = 4'b0010;
    wait_start(ok, n);
    checks++;
    if (!ok || gnt !== 4'b0010) $display("FAIL mid_grant got ok=%0d gnt=%b exp gnt=0010", ok, gnt);
    else passed++;
    req = '0; req_mode = '0; req_data[15:8] = ~d1;
    for (int c = 2; c <= 12; c++) begin
      @(negedge clk);
      checks++;
      if ({dt_mode_select, dt_parallel_in} !== {1'b1, d1})
        $display("FAIL mid_hold c=%0d got ms=%b pin=%h exp ms=1 pin=%h", c, dt_mode_select, dt_parallel_in, d1);
      else passed++;
    end
    checks++;
    if ({done, rdata} !== {4'b0010, m_rdata})
      $display("FAIL mid_done got done=%b rdata=%h exp done=0010 rdata=%h", done, rdata, m_rdata);
    else passed++;
    m_ptr = 2;
  endtask

  task automatic test_reset_mid_busy();
    bit ok; int n;
    logic [7:0] d3;
    rx_val = 8'($urandom);
    req = 4'b0001; req_mode = 4'b0000;
    wait_start(ok, n);
    checks++;
    if (!ok || gnt !== 4'b0001) $display("FAIL rst_mid_grant got ok=%0d gnt=%b exp 0001", ok, gnt);
    else passed++;
    req = '0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_ptr = 0; m_rdata = 8'h00;
    checks++;
    if ({gnt, done, busy, dt_start, dt_mode_select, dt_parallel_in, rdata} !== '0)
      $display("FAIL rst_mid_outputs got gnt=%b done=%b busy=%b st=%b ms=%b pin=%h rdata=%h exp all 0",
               gnt, done, busy, dt_start, dt_mode_select, dt_parallel_in, rdata);
    else passed++;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if ({done, busy} !== 5'b0) $display("FAIL rst_mid_no_done c=%0d got done=%b busy=%b exp 0", c, done, busy);
      else passed++;
    end
    d3 = 8'($urandom);
    req = 4'b1000; req_mode = 4'b1000; req_data = {d3, 24'h0};
    wait_start(ok, n);
    checks++;
    if (!ok || {gnt, dt_parallel_in} !== {4'b1000, d3})
      $display("FAIL rst_then_req3 got ok=%0d gnt=%b pin=%h exp gnt=1000 pin=%h", ok, gnt, dt_parallel_in, d3);
    else passed++;
    req = '0;
    repeat (11) @(negedge clk);
    checks++;
    if ({done, rdata} !== {4'b1000, m_rdata})
      $display("FAIL rst_then_done3 got done=%b rdata=%h exp done=1000 rdata=%h", done, rdata, m_rdata);
    else passed++;
    m_ptr = 0;
  endtask

  task automatic test_pointer_wrap();
    bit ok; int n, w;
    logic [3:0] expg;
    req = 4'b1001; req_mode = 4'b0000;
    for (int t = 0; t < 2; t++) begin
      rx_val = 8'($urandom);
      wait_start(ok, n);
      w = model_winner(4'b1001, m_ptr);
      expg = 4'd1 << w;
      checks++;
      if (!ok || gnt !== expg) $display("FAIL wrap_grant t=%0d got ok=%0d gnt=%b exp gnt=%b", t, ok, gnt, expg);
      else passed++;
      if (t == 1) req = '0;
      m_rdata = rx_val;
      repeat (11) @(negedge clk);
      checks++;
      if ({done, rdata} !== {expg, m_rdata})
        $display("FAIL wrap_done t=%0d got done=%b rdata=%h exp done=%b rdata=%h", t, done, rdata, expg, m_rdata);
      else passed++;
      m_ptr = (w + 1) % 4;
    end
  endtask

  task automatic test_random();
    bit ok; int n, w;
    logic [3:0] r, lm, expg; logic [31:0] ld;
    for (int it = 0; it < 25; it++) begin
      r = 4'($urandom_range(1, 15));
      lm = 4'($urandom); ld = $urandom;
      req = r; req_mode = lm; req_data = ld;
      rx_val = 8'($urandom);
      wait_start(ok, n);
      checks++;
      if (!ok) begin $display("FAIL rand_start_timeout it=%0d got none exp dt_start", it); return; end
      passed++;
      w = model_winner(r, m_ptr);
      expg = 4'd1 << w;
      checks++;
      if ({gnt, dt_mode_select, dt_parallel_in} !== {expg, lm[w], ld[w*8 +: 8]})
        $display("FAIL rand_grant it=%0d got gnt=%b ms=%b pin=%h exp gnt=%b ms=%b pin=%h",
                 it, gnt, dt_mode_select, dt_parallel_in, expg, lm[w], ld[w*8 +: 8]);
      else passed++;
      if ($urandom_range(0, 1) == 1) begin
        req = 4'($urandom); req_mode = 4'($urandom); req_data = $urandom;
      end
      if (!lm[w]) m_rdata = rx_val;
      repeat (11) @(negedge clk);
      checks++;
      if ({done, gnt, rdata, dt_mode_select, dt_parallel_in} !== {expg, expg, m_rdata, lm[w], ld[w*8 +: 8]})
        $display("FAIL rand_done it=%0d got done=%b gnt=%b rdata=%h pin=%h exp done=%b rdata=%h pin=%h",
                 it, done, gnt, rdata, dt_parallel_in, expg, m_rdata, ld[w*8 +: 8]);
      else passed++;
      m_ptr = (w + 1) % 4;
      if ($urandom_range(0, 3) == 0) begin
        req = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({gnt, busy, dt_mode_select, dt_parallel_in} !== {4'b0, 1'b0, lm[w], ld[w*8 +: 8]})
          $display("FAIL rand_idle it=%0d got gnt=%b busy=%b ms=%b pin=%h exp idle with held ms/pin",
                   it, gnt, busy, dt_mode_select, dt_parallel_in);
        else passed++;
      end
    end
    req = '0;
  endtask

  initial begin
    test_reset();
    test_single_rx();
    test_single_tx();
    test_round_robin();
    test_mid_flight();
    test_reset_mid_busy();
    test_pointer_wrap();
    test_random();
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
